// File: rtl/shift_reg_pkg.sv
// Shared encodings for the shift_reg_n operation select.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/dff_syn_n.sv
// WIDTH-bit flop bank with synchronous active-low reset, enable and reset value.
module dff_syn_n #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Reset wins over enable on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            q_q <= RST_VAL;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/shift_reg_n.sv
// Universal shift register with rotate, parallel load and a saturating
// count of non-rotating shifts since the last load or reset.
module shift_reg_n
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         rot,
    input  logic                         sin_r,
    input  logic                         sin_l,
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             q,
    output logic                         sout,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         empty
);

    localparam int CW = $clog2(WIDTH+1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             empty_q, empty_d;

    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        // Count saturates at WIDTH while the data keeps shifting.
        cnt_inc = (cnt_q == CW'(WIDTH)) ? cnt_q : cnt_q + CW'(1);
        case (mode_e'(mode))
            MODE_SHR: begin
                q_d = {(rot ? q_q[0] : sin_r), q_q[WIDTH-1:1]};
                if (!rot) cnt_d = cnt_inc;
            end
            MODE_SHL: begin
                q_d = {q_q[WIDTH-2:0], (rot ? q_q[WIDTH-1] : sin_l)};
                if (!rot) cnt_d = cnt_inc;
            end
            MODE_LOAD: begin
                q_d   = d;
                cnt_d = '0;
            end
            default: ;
        endcase
        empty_d = (cnt_d == CW'(WIDTH));
    end

    dff_syn_n #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_q_reg (
        .clk     (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .d_i     (q_d),
        .q_o     (q_q)
    );

    dff_syn_n #(.WIDTH(CW), .RST_VAL('0)) u_cnt_reg (
        .clk     (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .d_i     (cnt_d),
        .q_o     (cnt_q)
    );

    dff_syn_n #(.WIDTH(1), .RST_VAL(1'b0)) u_empty_reg (
        .clk     (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .d_i     (empty_d),
        .q_o     (empty_q)
    );

    assign q     = q_q;
    assign cnt   = cnt_q;
    assign empty = empty_q;
    assign sout  = (mode_e'(mode) == MODE_SHR) ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed bench for shift_reg_n: default instance plus one with RST_VAL=8'h5A.
module tb_shift_reg_n;

    logic       clk = 1'b0;
    logic       rst_n, en, rot, sin_r, sin_l;
    logic [1:0] mode;
    logic [7:0] d;

    logic [7:0] q, q2;
    logic       sout, sout2, empty, empty2;
    logic [3:0] cnt, cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_reg_n #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .d(d),
        .q(q), .sout(sout), .cnt(cnt), .empty(empty)
    );

    shift_reg_n #(.WIDTH(8), .RST_VAL(8'h5A)) dut_rv (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .d(d),
        .q(q2), .sout(sout2), .cnt(cnt2), .empty(empty2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic load(input logic [7:0] val);
        en = 1'b1; mode = 2'b11; d = val; rot = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mode = 2'b11; d = 8'hFF; rot = 1'b0;
        sin_r = 1'b0; sin_l = 1'b0;
        tick();
        chk("reset_q", q, 8'h00);
        chk("reset_cnt", {4'h0, cnt}, 8'h00);
        chk("reset_empty", {7'h0, empty}, 8'h00);
        chk("reset_q_rstval", q2, 8'h5A);
        rst_n = 1'b1;
        load(8'hC3);
        chk("load_c3", q, 8'hC3);
        // rst_n pulse entirely between edges must not touch state
        rst_n = 1'b0;
        #3;
        chk("async_rst_ignored", q, 8'hC3);
        rst_n = 1'b1;
        #1;
        chk("async_rst_ignored_after", q, 8'hC3);
    endtask

    task automatic test_shift_right();
        logic [7:0] exp_q [8];
        logic [7:0] exp_s;
        exp_q = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
        exp_s = 8'b1010_0101;  // sout before each edge, first edge in bit 7
        load(8'hA5);
        chk("shr_load_q", q, 8'hA5);
        chk("shr_load_cnt", {4'h0, cnt}, 8'h00);
        mode = 2'b01; sin_r = 1'b0; rot = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("shr_sout_%0d", i), {7'h0, sout}, {7'h0, exp_s[7-i]});
            tick();
            chk($sformatf("shr_q_%0d", i), q, exp_q[i]);
            chk($sformatf("shr_cnt_%0d", i), {4'h0, cnt}, 8'(i + 1));
            if (i == 6) chk("shr_empty_before_full", {7'h0, empty}, 8'h00);
        end
        chk("shr_empty", {7'h0, empty}, 8'h01);
    endtask

    task automatic test_rotate();
        load(8'h81);
        mode = 2'b10; rot = 1'b1; sin_l = 1'b0;
        #1;
        chk("rol_sout_msb", {7'h0, sout}, 8'h01);
        tick(); chk("rol_q_0", q, 8'h03);
        tick(); chk("rol_q_1", q, 8'h06);
        tick(); chk("rol_q_2", q, 8'h0C);
        chk("rol_cnt", {4'h0, cnt}, 8'h00);
        chk("rol_empty", {7'h0, empty}, 8'h00);
        load(8'h01);
        mode = 2'b01; rot = 1'b1; sin_r = 1'b0;
        tick();
        chk("ror_q", q, 8'h80);
        chk("ror_cnt", {4'h0, cnt}, 8'h00);
    endtask

    task automatic test_hold_saturation();
        mode = 2'b01; rot = 1'b0; sin_r = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("fill_q", q, 8'hFF);
        chk("fill_empty", {7'h0, empty}, 8'h01);
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("en0_q", q, 8'hFF);
        chk("en0_cnt", {4'h0, cnt}, 8'h08);
        en = 1'b1; mode = 2'b00;
        tick(); tick();
        chk("hold_q", q, 8'hFF);
        chk("hold_cnt", {4'h0, cnt}, 8'h08);
        mode = 2'b01; sin_r = 1'b0;
        tick(); chk("sat_q_0", q, 8'h7F);
        tick(); chk("sat_q_1", q, 8'h3F);
        tick(); chk("sat_q_2", q, 8'h1F);
        chk("sat_cnt", {4'h0, cnt}, 8'h08);
        chk("sat_empty", {7'h0, empty}, 8'h01);
        load(8'h3C);
        chk("reload_q", q, 8'h3C);
        chk("reload_cnt", {4'h0, cnt}, 8'h00);
        chk("reload_empty", {7'h0, empty}, 8'h00);
    endtask

    task automatic test_reset_mid();
        load(8'h00);
        mode = 2'b10; rot = 1'b0; sin_l = 1'b1;
        tick(); tick(); tick();
        chk("shl_q", q, 8'h07);
        chk("shl_cnt", {4'h0, cnt}, 8'h03);
        chk("shl_q_rstval", q2, 8'h07);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_q", q, 8'h00);
        chk("mid_rst_cnt", {4'h0, cnt}, 8'h00);
        chk("mid_rst_q_rstval", q2, 8'h5A);
        rst_n = 1'b1;
        tick();
        chk("post_rst_q", q, 8'h01);
        chk("post_rst_cnt", {4'h0, cnt}, 8'h01);
        chk("post_rst_q_rstval", q2, 8'hB5);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; mode = 2'b00; rot = 1'b0;
        sin_r = 1'b0; sin_l = 1'b0; d = 8'h00;
        #2;
        test_reset();
        test_shift_right();
        test_rotate();
        test_hold_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_n.md
SHIFT_REG_N -- requirements
Module: shift_reg_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, value loaded into q on reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port en, input, 1, operation enable; 0 = hold all state.
REQ-006 SHALL have port mode, input, 2, operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SHALL have port rot, input, 1, when 1, shifts rotate instead of taking serial input.
REQ-008 SHALL have port sin_r, input, 1, serial bit entering q[WIDTH-1] on right shift.
REQ-009 SHALL have port sin_l, input, 1, serial bit entering q[0] on left shift.
REQ-010 SHALL have port d, input, WIDTH, parallel load data.
REQ-011 SHALL have port q, output, WIDTH, registered contents.
REQ-012 SHALL have port sout, output, 1, bit shifted out: q[0] in right mode, q[WIDTH-1] otherwise (combinational from q and mode).
REQ-013 SHALL have port cnt, output, $clog2(WIDTH+1), non-rotating shifts since last load or reset.
REQ-014 SHALL have port empty, output, 1, registered, high when cnt == WIDTH.

Function
REQ-015 SHALL sample en, mode, rot, sin_r, sin_l and d only on the rising clk edge; q updates with one-cycle latency.
REQ-016 SHALL keep q and cnt unchanged when en=0 or mode=00.
REQ-017 SHALL, on right shift with rot=0, set q <= {sin_r, q[WIDTH-1:1]}.
REQ-018 SHALL, on left shift with rot=0, set q <= {q[WIDTH-2:0], sin_l}.
REQ-019 SHALL, on right shift with rot=1, set q <= {q[0], q[WIDTH-1:1]}, ignoring sin_r.
REQ-020 SHALL, on left shift with rot=1, set q <= {q[WIDTH-2:0], q[WIDTH-1]}, ignoring sin_l.
REQ-021 SHALL, on parallel load, set q <= d and cnt <= 0 regardless of rot.
REQ-022 SHALL increment cnt by 1 on each enabled non-rotating shift, saturating at WIDTH (no wrap-around).
REQ-023 SHALL leave cnt unchanged on rotating shifts.
REQ-024 SHALL assert empty in the cycle after cnt reaches WIDTH and deassert it in the cycle after a load or reset.
REQ-025 SHALL keep shifting q when cnt is saturated; only cnt stops counting.
REQ-026 SHALL give reset priority over en and every mode in the same edge.

Reset
REQ-027 SHALL, on a rising clk edge with rst_n=0, set q <= RST_VAL, cnt <= 0, empty <= 0.
REQ-028 SHALL NOT change any state on an rst_n transition alone, with no clk edge.
REQ-029 SHALL abandon an operation in progress on reset mid-sequence; the first edge with rst_n=1 executes the operation then presented.

Structure
REQ-030 SHALL take mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) from shared package shift_reg_pkg.
REQ-031 SHALL build the register from sub-module dff_syn_n: WIDTH-parametrised flop with synchronous active-low reset, enable and reset value.
REQ-032 SHALL compute next-state q, cnt and empty combinationally in shift_reg_n; sout is the only unregistered output.

Verification (WIDTH=8, RST_VAL=8'h00 unless stated)
REQ-033 SHALL check reset: rst_n=0 for 1 edge with en=1, mode=11, d=8'hFF -> q=8'h00, cnt=0, empty=0; with rst_n=0 and no clk edge, q unchanged.
REQ-034 SHALL check load and shift right: load 8'hA5, then 8 edges of SHR with sin_r=0, rot=0 -> q sequence 52,29,14,0A,05,02,01,00; sout = 1,0,1,0,0,1,0,1; cnt=8; empty=1 after the last edge.
REQ-035 SHALL check left rotate: load 8'h81, 3 edges of SHL with rot=1 -> q=03,06,0C; cnt=0; empty=0.
REQ-036 SHALL check hold, saturation and reload: from empty=1, 4 edges of SHR with en=0 and then 2 with mode=00 -> q unchanged; 3 more SHR with en=1 -> cnt stays 8; load 8'h3C -> q=3C, cnt=0, empty=0 after the next edge.
REQ-037 SHALL check reset mid-sequence: after 3 SHL with sin_l=1 from 8'h00 (q=07), rst_n=0 together with mode=10 -> q=00, cnt=0; rerun with RST_VAL=8'h5A -> q=5A.
